// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared states, HD44780 command codes and addressing helpers
package lcd_pkg;

  localparam logic [3:0] ST_PWRUP   = 4'd0;
  localparam logic [3:0] ST_FSET    = 4'd1;
  localparam logic [3:0] ST_DOFF    = 4'd2;
  localparam logic [3:0] ST_CLR     = 4'd3;
  localparam logic [3:0] ST_ENTRY   = 4'd4;
  localparam logic [3:0] ST_DON     = 4'd5;
  localparam logic [3:0] ST_IDLE    = 4'd6;
  localparam logic [3:0] ST_ROWADDR = 4'd7;
  localparam logic [3:0] ST_WRITE   = 4'd8;

  localparam logic [7:0] CMD_FSET  = 8'h38;
  localparam logic [7:0] CMD_DOFF  = 8'h08;
  localparam logic [7:0] CMD_CLR   = 8'h01;
  localparam logic [7:0] CMD_ENTRY = 8'h06;
  localparam logic [7:0] CMD_DON   = 8'h0C;
  localparam logic [7:0] CMD_DDRAM = 8'h80;

  // DDRAM start address of each display row on HD44780 panels
  function automatic logic [7:0] row_base(input logic [1:0] row);
    case (row)
      2'd0:    return 8'h00;
      2'd1:    return 8'h40;
      2'd2:    return 8'h14;
      default: return 8'h54;
    endcase
  endfunction

  // Flat buffer index of a (row, col) cell, row-major
  function automatic int cell_idx(input logic [1:0] row, input logic [4:0] col, input int cols);
    return int'(row) * cols + int'(col);
  endfunction

endpackage

// File: rtl/lcd_char_buf.sv
// rtl/lcd_char_buf.sv - ROWS x COLS character store, space-filled on reset
module lcd_char_buf
  import lcd_pkg::*;
#(
  parameter int ROWS = 2,
  parameter int COLS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [1:0] wr_row,
  input  logic [4:0] wr_col,
  input  logic [7:0] wr_char,
  input  logic [1:0] rd_row,
  input  logic [4:0] rd_col,
  output logic [7:0] rd_char
);

  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign wr_idx  = AW'(cell_idx(wr_row, wr_col, COLS));
  assign rd_idx  = AW'(cell_idx(rd_row, rd_col, COLS));
  assign rd_char = mem[rd_idx];

  // Host write port; reset blanks the whole screen to spaces
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[AW'(i)] <= 8'h20;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_char;
    end
  end

endmodule

// File: rtl/lcd_ctrl_buf.sv
// rtl/lcd_ctrl_buf.sv - HD44780 LCD controller with char buffer; LCD_ROW_DIRTY_EN selects per-row dirty tracking
module lcd_ctrl_buf
  import lcd_pkg::*;
#(
  parameter int ROWS          = 2,
  parameter int COLS          = 16,
  parameter int EN_PERIOD_CYC = 100000,
  parameter int PWRUP_CYC     = 750000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [1:0] wr_row,
  input  logic [4:0] wr_col,
  input  logic [7:0] wr_char,
  output logic       busy,
  output logic       init_done,
  output logic       lcd_on,
  output logic       lcd_rw,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  localparam int CW = $clog2(EN_PERIOD_CYC);
  localparam int PW = (PWRUP_CYC > 1) ? $clog2(PWRUP_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(EN_PERIOD_CYC - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(EN_PERIOD_CYC / 2);
  localparam logic [PW-1:0] PWR_LAST = PW'(PWRUP_CYC - 1);
  localparam logic [1:0]    ROW_LAST = 2'(ROWS - 1);
  localparam logic [4:0]    COL_LAST = 5'(COLS - 1);

  logic [3:0]    state, nxt_state;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [PW-1:0] pwr_cnt;
  logic [1:0]    row, nxt_row, first_row, next_row;
  logic [4:0]    col, nxt_col;
  logic          slot_end, wr_ok, enter_row, have_first, have_next;
  logic          nxt_rs;
  logic [7:0]    nxt_data, rd_char;

  assign lcd_on    = 1'b1;
  assign lcd_rw    = 1'b0;
  assign busy      = (state != ST_IDLE);
  assign slot_end  = (cnt == CNT_LAST);
  assign cnt_nxt   = slot_end ? '0 : cnt + 1'b1;
  assign wr_ok     = wr_en && (wr_row <= ROW_LAST) && (wr_col <= COL_LAST);
  assign enter_row = slot_end && (nxt_state == ST_ROWADDR);

`ifdef LCD_ROW_DIRTY_EN
  logic [ROWS-1:0] dirty;

  // Lowest dirty row overall, and lowest dirty row after the current one
  always_comb begin
    have_first = 1'b0;
    first_row  = 2'd0;
    have_next  = 1'b0;
    next_row   = 2'd0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (dirty[r]) begin
        have_first = 1'b1;
        first_row  = 2'(r);
      end
      if (dirty[r] && (2'(r) > row)) begin
        have_next = 1'b1;
        next_row  = 2'(r);
      end
    end
  end

  // Per-row dirty bits: host write sets its row, entering that row's address slot clears it; set wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dirty <= '1;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        if (wr_ok && (wr_row == 2'(r)))          dirty[r] <= 1'b1;
        else if (enter_row && (nxt_row == 2'(r))) dirty[r] <= 1'b0;
      end
    end
  end
`else
  logic dirty;

  assign have_first = dirty;
  assign first_row  = 2'd0;
  assign have_next  = (row < ROW_LAST);
  assign next_row   = row + 2'd1;

  // Single dirty bit: any valid write sets it, starting a full pass clears it; set wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                dirty <= 1'b1;
    else if (wr_ok)                            dirty <= 1'b1;
    else if (enter_row && (state == ST_IDLE))  dirty <= 1'b0;
  end
`endif

  lcd_char_buf #(.ROWS(ROWS), .COLS(COLS)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_ok),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_char (wr_char),
    .rd_row  (nxt_row),
    .rd_col  (nxt_col),
    .rd_char (rd_char)
  );

  // State/row/col that take effect at the next slot boundary
  always_comb begin
    nxt_state = state;
    nxt_row   = row;
    nxt_col   = col;
    case (state)
      ST_FSET:    nxt_state = ST_DOFF;
      ST_DOFF:    nxt_state = ST_CLR;
      ST_CLR:     nxt_state = ST_ENTRY;
      ST_ENTRY:   nxt_state = ST_DON;
      ST_DON:     nxt_state = ST_IDLE;
      ST_IDLE: begin
        if (have_first) begin
          nxt_state = ST_ROWADDR;
          nxt_row   = first_row;
        end
      end
      ST_ROWADDR: begin
        nxt_state = ST_WRITE;
        nxt_col   = 5'd0;
      end
      ST_WRITE: begin
        if (col < COL_LAST) begin
          nxt_col = col + 5'd1;
        end else if (have_next) begin
          nxt_state = ST_ROWADDR;
          nxt_row   = next_row;
        end else begin
          nxt_state = ST_IDLE;
        end
      end
      default:    nxt_state = state;
    endcase
  end

  // Bus value (rs, data) presented during the upcoming slot
  always_comb begin
    nxt_rs   = 1'b0;
    nxt_data = CMD_DON;
    case (nxt_state)
      ST_FSET:    nxt_data = CMD_FSET;
      ST_DOFF:    nxt_data = CMD_DOFF;
      ST_CLR:     nxt_data = CMD_CLR;
      ST_ENTRY:   nxt_data = CMD_ENTRY;
      ST_DON:     nxt_data = CMD_DON;
      ST_IDLE:    nxt_data = CMD_DON;
      ST_ROWADDR: nxt_data = CMD_DDRAM | row_base(nxt_row);
      ST_WRITE: begin
        nxt_rs   = 1'b1;
        nxt_data = rd_char;
      end
      default:    nxt_data = CMD_FSET;
    endcase
  end

  // Power-up wait, then free-running slot counter driving en and the per-slot bus update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_PWRUP;
      cnt       <= '0;
      pwr_cnt   <= '0;
      row       <= 2'd0;
      col       <= 5'd0;
      lcd_en    <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= 8'h00;
      init_done <= 1'b0;
    end else if (state == ST_PWRUP) begin
      cnt      <= '0;
      lcd_en   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= CMD_FSET;
      if (pwr_cnt == PWR_LAST) state <= ST_FSET;
      else                     pwr_cnt <= pwr_cnt + 1'b1;
    end else begin
      cnt    <= cnt_nxt;
      lcd_en <= (cnt_nxt >= CNT_HALF);
      if (slot_end) begin
        state    <= nxt_state;
        row      <= nxt_row;
        col      <= nxt_col;
        lcd_rs   <= nxt_rs;
        lcd_data <= nxt_data;
        if (state == ST_DON) init_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lcd_ctrl_buf.sv
// tb/tb_lcd_ctrl_buf.sv - scoreboard bench for lcd_ctrl_buf (2x16, 8-cycle slots)
module tb_lcd_ctrl_buf;
  import lcd_pkg::*;

`ifdef LCD_ROW_DIRTY_EN
  localparam bit ROW_DIRTY = 1'b1;
`else
  localparam bit ROW_DIRTY = 1'b0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0;
  logic [1:0] wr_row = 2'd0;
  logic [4:0] wr_col = 5'd0;
  logic [7:0] wr_char = 8'h00;
  logic       busy, init_done, lcd_on, lcd_rw, lcd_rs, lcd_en;
  logic [7:0] lcd_data;

  int total = 0, bad = 0, nev = 0;
  logic [8:0] exp_q[$];
  logic [7:0] mdl [4][32];
  logic       prev_en = 1'b0, prev_rs = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always #5 clk = ~clk;

  lcd_ctrl_buf #(.ROWS(2), .COLS(16), .EN_PERIOD_CYC(8), .PWRUP_CYC(20)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_char(wr_char), .busy(busy), .init_done(init_done), .lcd_on(lcd_on),
    .lcd_rw(lcd_rw), .lcd_rs(lcd_rs), .lcd_en(lcd_en), .lcd_data(lcd_data)
  );

  // Each falling lcd_en pops the scoreboard; an empty scoreboard means an idle 0C slot
  always @(negedge clk) begin : mon
    logic [8:0] got, want;
    if (!rst_n) begin
      prev_en = 1'b0;
    end else begin
      if (prev_en && !lcd_en) begin
        got = {prev_rs, prev_data};
        if (exp_q.size() > 0) want = exp_q.pop_front();
        else                  want = {1'b0, CMD_DON};
        total++;
        assert (got === want) else begin
          bad++;
          $error("FAIL slot%0d obs=%h exp=%h", nev, got, want);
        end
        nev++;
      end
      prev_en   = lcd_en;
      prev_rs   = lcd_rs;
      prev_data = lcd_data;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic init_mdl();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 32; c++) mdl[r][c] = 8'h20;
  endtask

  function automatic logic [1:0] rmask(input logic [1:0] m);
    return ROW_DIRTY ? m : 2'b11;
  endfunction

  task automatic push_pass(input logic [1:0] mask);
    for (int r = 0; r < 2; r++) begin
      if (mask[r]) begin
        exp_q.push_back({1'b0, CMD_DDRAM | row_base(2'(r))});
        for (int c = 0; c < 16; c++) exp_q.push_back({1'b1, mdl[2'(r)][5'(c)]});
      end
    end
  endtask

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h08});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h0C});
    push_pass(2'b11);
  endtask

  task automatic do_wr(input logic [1:0] r, input logic [4:0] c, input logic [7:0] ch);
    @(negedge clk);
    wr_en = 1'b1; wr_row = r; wr_col = c; wr_char = ch;
    @(negedge clk);
    wr_en = 1'b0;
    if (r < 2'd2 && c < 5'd16) mdl[r][c] = ch;
  endtask

  task automatic wait_ev(input int n);
    int target;
    int k;
    target = nev + n;
    k = 0;
    while (nev < target && k < 2000) begin
      @(posedge clk);
      k++;
    end
    if (nev < target) chk("ev_timeout", nev, target);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 5000) begin
      @(posedge clk);
      k++;
    end
    chk("drain", exp_q.size(), 0);
    wait_ev(2);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_en"},   32'(lcd_en), 0);
    chk({tag, "_rs"},   32'(lcd_rs), 0);
    chk({tag, "_data"}, 32'(lcd_data), 0);
    chk({tag, "_busy"}, 32'(busy), 1);
    chk({tag, "_init"}, 32'(init_done), 0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    int k;
    init_mdl();
    #3;
    chk_reset("rst");
    chk("lcd_on", 32'(lcd_on), 1);
    chk("lcd_rw", 32'(lcd_rw), 0);
    push_init();
    @(negedge clk);
    rst_n = 1'b1;
    drain();
    chk("init_done", 32'(init_done), 1);
    chk("idle_busy", 32'(busy), 0);

    // two writes in IDLE -> one pass, busy for 34 slots
    wait_ev(1);
    exp_q.push_back({1'b0, CMD_DON});
    do_wr(2'd0, 5'd0, 8'h35);
    do_wr(2'd1, 5'd15, 8'h39);
    push_pass(rmask(2'b11));
    k = 0;
    while (!busy && k < 100) begin @(negedge clk); k++; end
    n = 0;
    while (busy && n < 1000) begin @(negedge clk); n++; end
    chk("busy_cycles", n, 34 * 8);
    drain();

    // write to an already-sent cell while row 1 is going out -> one more pass
    wait_ev(1);
    exp_q.push_back({1'b0, CMD_DON});
    do_wr(2'd0, 5'd0, 8'h41);
    do_wr(2'd1, 5'd1, 8'h62);
    push_pass(rmask(2'b11));
    wait_ev(20);
    do_wr(2'd0, 5'd3, 8'h58);
    exp_q.push_back({1'b0, CMD_DON});
    push_pass(rmask(2'b01));
    drain();

    // out-of-range writes are ignored
    wait_ev(1);
    do_wr(2'd2, 5'd0, 8'h45);
    do_wr(2'd0, 5'd16, 8'h46);
    n = 0;
    repeat (48) begin @(negedge clk); if (busy) n++; end
    chk("bad_wr_busy", n, 0);

    // row-1-only write
    wait_ev(1);
    exp_q.push_back({1'b0, CMD_DON});
    do_wr(2'd1, 5'd4, 8'h5A);
    push_pass(rmask(2'b10));
    drain();

    // reset in the middle of WRITE
    wait_ev(1);
    exp_q.push_back({1'b0, CMD_DON});
    do_wr(2'd0, 5'd0, 8'h52);
    push_pass(rmask(2'b01));
    wait_ev(4);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset("midrst");
    exp_q.delete();
    init_mdl();
    repeat (3) @(negedge clk);
    push_init();
    rst_n = 1'b1;
    drain();
    chk("reinit_done", 32'(init_done), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
